// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle control FSM: states, opcodes and datapath select codes.
// Build option: define MCU_JUMP_EN to make the J opcode and JUMP state legal.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StAddiEx = 4'd9,
    StAddiWb = 4'd10,
    StJump   = 4'd11
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;

  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  localparam logic [1:0] PcAlu    = 2'b00;
  localparam logic [1:0] PcAluOut = 2'b01;
  localparam logic [1:0] PcJump   = 2'b10;

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OpLw, OpSw, OpRtype, OpBeq, OpAddi: return 1'b1;
`ifdef MCU_JUMP_EN
      OpJ: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // Unused encodings (and JUMP when it is compiled out) behave as FETCH.
  function automatic state_e norm_state(input logic [3:0] s);
    if (s > 4'd11) return StFetch;
`ifndef MCU_JUMP_EN
    if (s == 4'd11) return StFetch;
`endif
    return state_e'(s);
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational Moore output decode: state plus memory-ready/timeout to datapath strobes.
// Build option: MCU_JUMP_EN adds the JUMP state outputs.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic       active,
  input  logic [3:0] state,
  input  logic       ready,
  input  logic       timeout,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic       instr_done
);

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SrcBReg;
    PCSource    = PcAlu;
    ALUOp       = AluAdd;
    instr_done  = 1'b0;
    if (active) begin
      unique case (state_e'(state))
        StFetch: begin
          MemRead = 1'b1;
          ALUSrcB = SrcBFour;
          IRWrite = ready;
          PCWrite = ready;
        end
        StDecode: begin
          ALUSrcB = SrcBImmSh;
        end
        StMemAdr, StAddiEx: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SrcBImm;
        end
        StMemRd: begin
          IorD    = 1'b1;
          MemRead = 1'b1;
        end
        StMemWb: begin
          MemtoReg   = 1'b1;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        StMemWr: begin
          IorD       = 1'b1;
          // An aborted store must not leave a write strobe on the bus.
          MemWrite   = ~timeout;
          instr_done = ready;
        end
        StExec: begin
          ALUSrcA = 1'b1;
          ALUOp   = AluFunct;
        end
        StAluWb: begin
          RegDst     = 1'b1;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        StBranch: begin
          ALUSrcA     = 1'b1;
          ALUOp       = AluSub;
          PCSource    = PcAluOut;
          PCWriteCond = 1'b1;
          instr_done  = 1'b1;
        end
        StAddiWb: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
`ifdef MCU_JUMP_EN
        StJump: begin
          PCSource   = PcJump;
          PCWrite    = 1'b1;
          instr_done = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle processor control FSM with optional memory wait and wait-timeout abort.
// Build option: define MCU_JUMP_EN to enable the J instruction (opcode 000010, JUMP state).
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT     = 1,
  parameter int unsigned WAIT_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_timeout
);

  localparam int unsigned CntW = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(WAIT_TIMEOUT);

  state_e          state_q, state_d, cur;
  logic [CntW-1:0] wait_cnt;
  logic            active, ready, mem_state, timeout, legal;

  // The branch decision is taken in the datapath through PCWriteCond.
  logic unused_zero;
  assign unused_zero = zero;

  assign active    = ~reset;
  assign ready     = (MEM_WAIT == 0) ? 1'b1 : mem_ready;
  assign cur       = norm_state(state_q);
  assign mem_state = (cur == StFetch) || (cur == StMemRd) || (cur == StMemWr);
  assign timeout   = (WAIT_TIMEOUT != 0) && mem_state && !ready && (wait_cnt == CntMax);
  assign legal     = op_legal(opcode);

  always_comb begin
    state_d = cur;
    unique case (cur)
      StFetch:  if (ready) state_d = StDecode;
      StDecode: begin
        state_d = StFetch;
        if (legal) begin
          case (opcode)
            OpLw, OpSw: state_d = StMemAdr;
            OpRtype:    state_d = StExec;
            OpBeq:      state_d = StBranch;
            OpAddi:     state_d = StAddiEx;
`ifdef MCU_JUMP_EN
            OpJ:        state_d = StJump;
`endif
            default:    state_d = StFetch;
          endcase
        end
      end
      StMemAdr: state_d = (opcode == OpSw) ? StMemWr : StMemRd;
      StMemRd:  if (ready) state_d = StMemWb;
      StMemWr:  if (ready) state_d = StFetch;
      StExec:   state_d = StAluWb;
      StAddiEx: state_d = StAddiWb;
      default:  state_d = StFetch;
    endcase
    if (timeout) state_d = StFetch;
  end

  // Counter restarts on every state change (and on a timeout retry into FETCH).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StFetch;
      wait_cnt <= '0;
    end else begin
      state_q <= state_d;
      if ((state_d != state_q) || timeout) begin
        wait_cnt <= '0;
      end else if (!ready && (wait_cnt != CntMax)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  assign state       = state_q;
  assign illegal_op  = active && (cur == StDecode) && !legal;
  assign mem_timeout = active && timeout;

  mc_ctrl_decode u_decode (
    .active      (active),
    .state       (cur),
    .ready       (ready),
    .timeout     (timeout),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegWrite    (RegWrite),
    .RegDst      (RegDst),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .PCSource    (PCSource),
    .ALUOp       (ALUOp),
    .instr_done  (instr_done)
  );

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: instruction-sequence model checked every cycle plus directed checks.
// Honours MCU_JUMP_EN for the J instruction expectations.
module tb_mc_control_fsm;

  localparam int Timeout = 4;
  localparam int BPcw = 22, BPcc = 21, BIord = 20, BMrd = 19, BMwr = 18, BIrw = 17, BM2r = 16;
  localparam int BRegw = 15, BRdst = 14, BSrca = 13, BSrcb = 11, BPcs = 9, BAlu = 7, BSt = 3;
  localparam int BDone = 2, BIll = 1, BTo = 0;

  logic       clk, reset, zero, mem_ready;
  logic [5:0] opcode;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite;
  logic       RegDst, ALUSrcA, instr_done, illegal_op, mem_timeout;
  logic [1:0] ALUSrcB, PCSource, ALUOp;
  logic [3:0] state;
  logic [22:0] dut_w;
  logic [22:0] rec [16];

  int total = 0;
  int bad = 0;
  int m_step = 0;
  int m_wait = 0;

  mc_control_fsm #(.MEM_WAIT(1), .WAIT_TIMEOUT(Timeout)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUOp(ALUOp), .state(state), .instr_done(instr_done), .illegal_op(illegal_op),
    .mem_timeout(mem_timeout)
  );

  assign dut_w = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite,
                  RegDst, ALUSrcA, ALUSrcB, PCSource, ALUOp, state, instr_done, illegal_op,
                  mem_timeout};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // State visited at step idx of the instruction with this opcode; -1 once it is complete.
  function automatic int route(input logic [5:0] op, input int idx);
    if (idx == 0) return 0;
    if (idx == 1) return 1;
    case (op)
      6'b100011: return (idx == 2) ? 2 : (idx == 3) ? 3 : (idx == 4) ? 4 : -1;
      6'b101011: return (idx == 2) ? 2 : (idx == 3) ? 5 : -1;
      6'b000000: return (idx == 2) ? 6 : (idx == 3) ? 7 : -1;
      6'b000100: return (idx == 2) ? 8 : -1;
      6'b001000: return (idx == 2) ? 9 : (idx == 3) ? 10 : -1;
`ifdef MCU_JUMP_EN
      6'b000010: return (idx == 2) ? 11 : -1;
`endif
      default:   return -1;
    endcase
  endfunction

  function automatic logic is_mem(input int st);
    return (st == 0) || (st == 3) || (st == 5);
  endfunction

  function automatic logic [22:0] exp_word(input int st, input logic rdy, input logic to,
                                           input logic ill);
    logic [22:0] w;
    w = '0;
    w[BSt +: 4] = st[3:0];
    case (st)
      0:  begin w[BMrd] = 1'b1; w[BSrcb +: 2] = 2'b01; w[BIrw] = rdy; w[BPcw] = rdy; end
      1:  begin w[BSrcb +: 2] = 2'b11; w[BIll] = ill; end
      2, 9: begin w[BSrca] = 1'b1; w[BSrcb +: 2] = 2'b10; end
      3:  begin w[BIord] = 1'b1; w[BMrd] = 1'b1; end
      4:  begin w[BM2r] = 1'b1; w[BRegw] = 1'b1; w[BDone] = 1'b1; end
      5:  begin w[BIord] = 1'b1; w[BMwr] = ~to; w[BDone] = rdy; end
      6:  begin w[BSrca] = 1'b1; w[BAlu +: 2] = 2'b10; end
      7:  begin w[BRdst] = 1'b1; w[BRegw] = 1'b1; w[BDone] = 1'b1; end
      8:  begin
        w[BSrca] = 1'b1; w[BAlu +: 2] = 2'b01; w[BPcs +: 2] = 2'b01;
        w[BPcc] = 1'b1; w[BDone] = 1'b1;
      end
      10: begin w[BRegw] = 1'b1; w[BDone] = 1'b1; end
      11: begin w[BPcs +: 2] = 2'b10; w[BPcw] = 1'b1; w[BDone] = 1'b1; end
      default: ;
    endcase
    w[BTo] = to;
    return w;
  endfunction

  always @(posedge clk) begin : model
    int st;
    if (reset) begin
      m_step = 0;
      m_wait = 0;
    end else begin
      st = route(opcode, m_step);
      if (is_mem(st) && !mem_ready) begin
        if (m_wait == Timeout) begin
          m_step = 0;
          m_wait = 0;
        end else begin
          m_wait++;
        end
      end else begin
        m_wait = 0;
        m_step++;
        if (route(opcode, m_step) < 0) m_step = 0;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [22:0] e;
    int st;
    logic to, ill;
    if (reset) begin
      e = '0;
    end else begin
      st  = route(opcode, m_step);
      to  = is_mem(st) && !mem_ready && (m_wait == Timeout);
      ill = (st == 1) && (route(opcode, 2) < 0);
      e   = exp_word(st, mem_ready, to, ill);
    end
    chk("cycle", {9'd0, dut_w}, {9'd0, e});
  end

  task automatic cycles(input int n, input logic [15:0] rdy);
    for (int i = 0; i < n; i++) begin
      mem_ready = rdy[i];
      zero = ~zero;
      #2;
      rec[i] = dut_w;
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int cnt_bit(input int n, input int b);
    int c;
    c = 0;
    for (int i = 0; i < n; i++) c += int'(rec[i][b]);
    return c;
  endfunction

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1);
  end

  initial begin : stim
    reset = 1'b1;
    opcode = 6'b000000;
    mem_ready = 1'b0;
    zero = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk("reset_outputs", {9'd0, dut_w}, 32'd0);
    chk("reset_memread", {31'd0, MemRead}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    opcode = 6'b100011;
    cycles(5, 16'h001f);
    for (int i = 0; i < 5; i++) chk("lw_state", {28'd0, rec[i][BSt +: 4]}, i);
    chk("lw_wb_regwrite", {31'd0, rec[4][BRegw]}, 32'd1);
    chk("lw_wb_memtoreg", {31'd0, rec[4][BM2r]}, 32'd1);
    chk("lw_done_count", cnt_bit(5, BDone), 32'd1);

    opcode = 6'b101011;
    cycles(7, 16'b1000111);
    chk("sw_memwrite_cycles", cnt_bit(7, BMwr), 32'd4);
    chk("sw_done_count", cnt_bit(7, BDone), 32'd1);
    chk("sw_done_on_ready", {31'd0, rec[6][BDone]}, 32'd1);

    opcode = 6'b000100;
    cycles(3, 16'h0007);
    chk("beq_pcwritecond", {31'd0, rec[2][BPcc]}, 32'd1);
    chk("beq_aluop", {30'd0, rec[2][BAlu +: 2]}, 32'd1);
    chk("beq_pcsource", {30'd0, rec[2][BPcs +: 2]}, 32'd1);

    opcode = 6'b000000;
    cycles(4, 16'h000f);
    chk("r_aluop", {30'd0, rec[2][BAlu +: 2]}, 32'd2);
    chk("r_regdst", {31'd0, rec[3][BRdst]}, 32'd1);
    chk("r_regwrite", {31'd0, rec[3][BRegw]}, 32'd1);

    opcode = 6'b001000;
    cycles(6, 16'b111100);
    chk("fetch_wait_irwrite", {31'd0, rec[0][BIrw]}, 32'd0);
    chk("fetch_ready_irwrite", {31'd0, rec[2][BIrw]}, 32'd1);
    chk("addi_wb_state", {28'd0, rec[5][BSt +: 4]}, 32'd10);

    opcode = 6'b111111;
    cycles(3, 16'b011);
    chk("illegal_pulse_count", cnt_bit(3, BIll), 32'd1);
    chk("illegal_at_decode", {31'd0, rec[1][BIll]}, 32'd1);
    chk("illegal_next_fetch", {28'd0, rec[2][BSt +: 4]}, 32'd0);

    opcode = 6'b000010;
    cycles(3, 16'b011);
`ifdef MCU_JUMP_EN
    chk("j_pcsource", {30'd0, rec[2][BPcs +: 2]}, 32'd2);
    chk("j_pcwrite", {31'd0, rec[2][BPcw]}, 32'd1);
`else
    chk("j_illegal", {31'd0, rec[1][BIll]}, 32'd1);
    chk("j_no_pcsource", {30'd0, rec[2][BPcs +: 2]}, 32'd0);
`endif

    opcode = 6'b100011;
    cycles(9, 16'b000000111);
    chk("lw_timeout_5th_wait", {31'd0, rec[7][BTo]}, 32'd1);
    chk("lw_timeout_count", cnt_bit(9, BTo), 32'd1);
    chk("lw_timeout_then_fetch", {28'd0, rec[8][BSt +: 4]}, 32'd0);
    chk("lw_timeout_no_regwrite", cnt_bit(9, BRegw), 32'd0);

    opcode = 6'b101011;
    cycles(8, 16'b00000111);
    chk("sw_timeout_pulse", {31'd0, rec[7][BTo]}, 32'd1);
    chk("sw_timeout_no_write", {31'd0, rec[7][BMwr]}, 32'd0);
    chk("sw_timeout_write_held", cnt_bit(8, BMwr), 32'd4);
    chk("sw_timeout_no_done", cnt_bit(8, BDone), 32'd0);

    opcode = 6'b101011;
    cycles(4, 16'b0111);
    #1;
    chk("memwr_before_reset", {31'd0, MemWrite}, 32'd1);
    reset = 1'b1;
    #1;
    chk("reset_drops_memwrite", {31'd0, MemWrite}, 32'd0);
    chk("reset_state_now", {28'd0, state}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("after_reset_state", {28'd0, state}, 32'd0);
    chk("after_reset_memread", {31'd0, MemRead}, 32'd1);

    opcode = 6'b000000;
    cycles(4, 16'h000f);
    chk("recover_r_wb", {28'd0, rec[3][BSt +: 4]}, 32'd7);

    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 Parameter MEM_WAIT, default 1, meaning 1 = memory states wait on mem_ready and 0 = mem_ready ignored (treated as 1).
REQ-002 Parameter WAIT_TIMEOUT, default 0, meaning max wait cycles per memory access, where 0 = no timeout.
REQ-003 The module SHALL have one clock and an asynchronous, active-high reset, with ports as follows.
  - clk  in  1  rising-edge clock
  - reset  in  1  asynchronous, active-high reset
REQ-004 The module SHALL have the following data and handshake ports.
  - opcode  in  6  instruction opcode from the externally latched IR; valid from DECODE onward
  - zero  in  1  ALU zero flag; informational only, since the branch qualifies externally via PCWriteCond
  - mem_ready  in  1  memory access completes this cycle
  - PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, RegDst, ALUSrcA  out  1 each  datapath strobes and selects
  - ALUSrcB  out  2  ALU B select: 00 = reg, 01 = const 4, 10 = sign-ext imm, 11 = imm<<2
  - PCSource  out  2  PC select: 00 = ALU, 01 = ALUOut, 10 = jump target
  - ALUOp  out  2  ALU operation: 00 = add, 01 = sub, 10 = use funct
  - state  out  4  current state, for debug
  - instr_done  out  1  one-cycle pulse on the final cycle of an instruction
  - illegal_op  out  1  one-cycle pulse when an unsupported opcode is decoded
  - mem_timeout  out  1  one-cycle pulse when a memory wait is aborted

Function
REQ-005 The block SHALL be a multi-cycle Moore FSM with these states and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
REQ-006 In FETCH, the outputs SHALL be: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=1 and PCWrite=1 only in the cycle where mem_ready=1.
REQ-007 FETCH SHALL go to DECODE when mem_ready=1 and otherwise remain in FETCH.
REQ-008 In DECODE, the outputs SHALL be ALUSrcA=0, ALUSrcB=11, ALUOp=00.
REQ-009 DECODE SHALL dispatch on opcode as follows.
  - 100011 (LW) or 101011 (SW) -> MEMADR
  - 000000 (R-type) -> EXEC
  - 000100 (BEQ) -> BRANCH
  - 001000 (ADDI) -> ADDIEX
  - 000010 (J) -> JUMP
  - any other opcode -> FETCH, with illegal_op=1 in that DECODE cycle
REQ-010 In MEMADR and ADDIEX, the outputs SHALL be ALUSrcA=1, ALUSrcB=10, ALUOp=00; MEMADR goes to MEMRD on LW and MEMWR on SW; ADDIEX goes to ADDIWB.
REQ-011 In MEMRD (IorD=1, MemRead=1), the FSM SHALL hold until mem_ready=1, then go to MEMWB.
REQ-012 MEMWB SHALL assert RegDst=0, MemtoReg=1, RegWrite=1 and then go to FETCH.
REQ-013 In MEMWR (IorD=1, MemWrite=1), the FSM SHALL hold until mem_ready=1, then go to FETCH.
REQ-014 EXEC SHALL assert ALUSrcA=1, ALUSrcB=00, ALUOp=10 and go to ALUWB.
REQ-015 ALUWB SHALL assert RegDst=1, MemtoReg=0, RegWrite=1 and go to FETCH.
REQ-016 ADDIWB SHALL assert RegDst=0, MemtoReg=0, RegWrite=1 and go to FETCH.
REQ-017 BRANCH SHALL assert ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, PCWriteCond=1 and go to FETCH.
REQ-018 JUMP SHALL assert PCSource=10, PCWrite=1 and go to FETCH.
REQ-019 Every output not listed for a state SHALL be 0.
REQ-020 instr_done SHALL be 1 in MEMWB, ALUWB, ADDIWB, BRANCH and JUMP, and in MEMWR when mem_ready=1.
REQ-021 With zero wait states, instruction latency in cycles SHALL be: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3.
REQ-022 A wait counter of width $clog2(WAIT_TIMEOUT+1) SHALL clear on entry to FETCH, MEMRD or MEMWR and increment each cycle with mem_ready=0.
REQ-023 When WAIT_TIMEOUT>0 and the wait counter equals WAIT_TIMEOUT with mem_ready=0, the FSM SHALL pulse mem_timeout, assert no write strobe, and go to FETCH; the counter saturates and never wraps.
REQ-024 If mem_ready=1 and the timeout condition coincide, mem_ready SHALL win (normal completion, no mem_timeout).
REQ-025 With MEM_WAIT=0, every memory state SHALL last exactly one cycle and the wait counter is unused.

Reset
REQ-026 Asserting reset SHALL asynchronously set state=FETCH and the wait counter to 0.
REQ-027 While reset is high, all outputs SHALL be 0, including strobes, selects and pulses.
REQ-028 Reset asserted mid-instruction SHALL abort the instruction with no further strobes; after deassertion the first active cycle is FETCH.

Configuration
REQ-029 Macro MCU_JUMP_EN defined SHALL enable the JUMP state and the 000010 dispatch.
REQ-030 Without MCU_JUMP_EN, opcode 000010 SHALL be illegal (illegal_op pulse, return to FETCH), and encoding 11 SHALL be unreachable and treated as FETCH.

Structure
REQ-031 Shared package mc_ctrl_pkg SHALL hold the state encodings, the opcode constants (R-type, LW, SW, BEQ, ADDI, J), and the ALUOp, ALUSrcB and PCSource codes.
REQ-032 The block SHALL contain one combinational sub-module, mc_ctrl_decode, mapping state and mem_ready to the output strobes.

Verification
REQ-033 LW, MEM_WAIT=1, mem_ready always 1: states SHALL be 0,1,2,3,4; RegWrite=1 and MemtoReg=1 in cycle 5; instr_done pulses once.
REQ-034 SW, mem_ready low for 3 cycles in MEMWR: MemWrite SHALL be held 4 cycles; instr_done only on the ready cycle.
REQ-035 BEQ: cycle 3 SHALL show PCWriteCond=1, ALUOp=01, PCSource=01; R-type: cycle 3 ALUOp=10, cycle 4 RegDst=1 and RegWrite=1.
REQ-036 Opcode 111111 at DECODE: illegal_op SHALL pulse once and the next state is FETCH; opcode 000010 SHALL give PCSource=10 only with MCU_JUMP_EN.
REQ-037 WAIT_TIMEOUT=4, mem_ready stuck 0 in MEMRD: mem_timeout SHALL pulse on the 5th wait cycle, then FETCH, with no RegWrite.
REQ-038 Reset asserted during MEMWR: MemWrite SHALL drop to 0 immediately; after release, state=0.
